// File: rtl/bpsk_demod.sv
// rtl/bpsk_demod.sv - coherent BPSK integrate-and-dump demodulator with carrier lock detect
//
// Multiplies each received sample by the local reference sine, integrates the
// product over one bit period and dumps the integral on every rising edge of
// the bit clock, deciding the bit from the sign of the integral.
//
// Ports:
//   clk         system clock (2 MHz), all logic on its rising edge
//   rst         asynchronous active-high reset
//   clk_data    bit clock (2400 Hz) from the clk domain, rising edge marks a bit boundary
//   demod_ena   level-sensitive enable; low forces IDLE on the next clk
//   bpsk_in     received signed 8-bit sample, one per clk
//   sine_ref    signed 8-bit local reference sine, phase-aligned to the carrier
//   ena_demod   high in WAIT_EDGE and INTEGRATE
//   data_out    last decided bit (1 = positive correlation)
//   data_valid  one-cycle pulse with each data_out update
//   carrier_det high once LOCK_BITS consecutive strong bits have been seen
module bpsk_demod #(
    parameter int ACC_W     = 28,
    parameter int THRESH    = 1048576,
    parameter int LOCK_BITS = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_data,
    input  logic              demod_ena,
    input  logic signed [7:0] bpsk_in,
    input  logic signed [7:0] sine_ref,
    output logic              ena_demod,
    output logic              data_out,
    output logic              data_valid,
    output logic              carrier_det
);

    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_BITS + 1);

    localparam logic signed [ACC_W-1:0] THR_POS  = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_NEG  = -THR_POS;
    localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0]       GOOD_MAX = GOOD_W'(LOCK_BITS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        INTEGRATE
    } state_t;

    state_t                    state, state_nxt;
    logic                      xa, xb;
    logic signed [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]          cyc_cnt, cyc_nxt;
    logic [GOOD_W-1:0]         good_cnt, good_nxt;
    logic                      data_out_nxt, data_valid_nxt, carrier_nxt;

    logic signed [15:0]        prod;
    logic signed [ACC_W-1:0]   p_ext;
    logic                      bit_edge;
    logic                      acc_strong;
    logic [GOOD_W-1:0]         good_inc;
    logic [GOOD_W-1:0]         good_dec;

    assign prod     = 16'(bpsk_in) * 16'(sine_ref);
    assign p_ext    = ACC_W'(prod);
    assign bit_edge = xa & ~xb;

    // Magnitude test done as two signed compares so no negation of acc is needed.
    assign acc_strong = (acc >= THR_POS) || (acc <= THR_NEG);
    assign good_inc   = (good_cnt == GOOD_MAX) ? GOOD_MAX : good_cnt + GOOD_W'(1);
    assign good_dec   = acc_strong ? good_inc : '0;

    assign ena_demod = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cyc_nxt        = cyc_cnt;
        good_nxt       = good_cnt;
        data_out_nxt   = data_out;
        data_valid_nxt = 1'b0;
        carrier_nxt    = carrier_det;

        if (!demod_ena) begin
            // Disable beats everything, including a decision on this edge cycle.
            state_nxt   = IDLE;
            acc_nxt     = '0;
            cyc_nxt     = '0;
            good_nxt    = '0;
            carrier_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    // First boundary only starts integration; the partial bit before it is dropped.
                    if (bit_edge) begin
                        state_nxt = INTEGRATE;
                        acc_nxt   = p_ext;
                        cyc_nxt   = CNT_W'(1);
                    end
                end
                INTEGRATE: begin
                    if (bit_edge) begin
                        // Dump and restart in one cycle: the edge-cycle product opens the next bit.
                        data_out_nxt   = ~acc[ACC_W-1];
                        data_valid_nxt = 1'b1;
                        acc_nxt        = p_ext;
                        cyc_nxt        = CNT_W'(1);
                        good_nxt       = good_dec;
                        carrier_nxt    = (good_dec == GOOD_MAX);
                    end else if (cyc_cnt == CNT_MAX) begin
                        state_nxt   = WAIT_EDGE;
                        acc_nxt     = '0;
                        cyc_nxt     = '0;
                        good_nxt    = '0;
                        carrier_nxt = 1'b0;
                    end else begin
                        acc_nxt = acc + p_ext;
                        cyc_nxt = cyc_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            xa          <= 1'b0;
            xb          <= 1'b0;
            acc         <= '0;
            cyc_cnt     <= '0;
            good_cnt    <= '0;
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            carrier_det <= 1'b0;
        end else begin
            state       <= state_nxt;
            xa          <= clk_data;
            xb          <= xa;
            acc         <= acc_nxt;
            cyc_cnt     <= cyc_nxt;
            good_cnt    <= good_nxt;
            data_out    <= data_out_nxt;
            data_valid  <= data_valid_nxt;
            carrier_det <= carrier_nxt;
        end
    end

endmodule
